// File: rtl/sync_fifo_pkg.sv
// Shared constants and elaboration-time helpers for the single-clock FIFO.
package sync_fifo_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 16;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // The count must hold the value DEPTH itself, so it is one bit wider than an address.
    function automatic int countWidth(input int depth);
        return clog2(depth) + 1;
    endfunction

    function automatic bit isPow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W simple dual-port storage: synchronous write, asynchronous read.
module fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              wrEn_i,
    input  logic [ADDR_W-1:0] wrAddr_i,
    input  logic [DATA_W-1:0] wrData_i,
    input  logic [ADDR_W-1:0] rdAddr_i,
    output logic [DATA_W-1:0] rdData_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage is never reset; only the pointers define which entries are live.
    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            mem_q[wrAddr_i] <= wrData_i;
        end
    end

    assign rdData_o = mem_q[rdAddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with threshold flags, sticky error flags,
// synchronous flush and selectable first-word-fall-through read mode.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter bit FWFT     = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         wr_en,
    input  logic [DATA_W-1:0]            wr_data,
    output logic                         w_full,
    output logic                         w_almost_full,
    input  logic                         rd_en,
    output logic [DATA_W-1:0]            data_out,
    output logic                         r_empty,
    output logic                         r_almost_empty,
    output logic [countWidth(DEPTH)-1:0] fill_count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    if (!isPow2(DEPTH) || DEPTH < 4) begin : gBadDepth
        $error("sync_fifo_param: DEPTH must be a power of two and at least 4");
    end
    if (!(AE_LEVEL < AF_LEVEL) || AF_LEVEL > DEPTH) begin : gBadLevels
        $error("sync_fifo_param: thresholds must satisfy AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wrAccept, rdAccept;
    logic [DATA_W-1:0] headWord;

    // Flags come only from the count register so no request input reaches them combinationally.
    assign w_full         = (count_q == CNT_W'(DEPTH));
    assign w_almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    assign r_empty        = (count_q == '0);
    assign r_almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    assign fill_count     = count_q;
    assign overflow       = overflow_q;
    assign underflow      = underflow_q;

    always_comb begin
        wrAccept    = wr_en && !w_full && !clear;
        rdAccept    = rd_en && !r_empty && !clear;
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (wr_en & w_full);
        underflow_d = underflow_q | (rd_en & r_empty);
        if (clear) begin
            wrPtr_d     = '0;
            rdPtr_d     = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wrAccept) begin
                wrPtr_d = wrPtr_q + ADDR_W'(1);
            end
            if (rdAccept) begin
                rdPtr_d = rdPtr_q + ADDR_W'(1);
            end
            case ({wrAccept, rdAccept})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) uRam (
        .clk_i    (clk),
        .wrEn_i   (wrAccept),
        .wrAddr_i (wrPtr_q),
        .wrData_i (wr_data),
        .rdAddr_i (rdPtr_q),
        .rdData_o (headWord)
    );

    if (FWFT) begin : gFwft
        assign data_out = r_empty ? '0 : headWord;
    end else begin : gStd
        logic [DATA_W-1:0] dataOut_q;

        // Holds its value through a flush; only an accepted read reloads it.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                dataOut_q <= '0;
            end else if (rdAccept) begin
                dataOut_q <= headWord;
            end
        end

        assign data_out = dataOut_q;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: one standard-read and one FWFT instance share stimulus
// and are compared against a queue-based reference model plus fixed vectors.
module tb_sync_fifo_param;

    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic       clk;
    logic       reset_n;
    logic       clear;
    logic       wrEn;
    logic [7:0] wrData;
    logic       rdEn;

    logic       wFull0, wAf0, rEmpty0, rAe0, ovf0, unf0;
    logic [7:0] dataOut0;
    logic [4:0] fillCount0;
    logic       wFull1, wAf1, rEmpty1, rAe1, ovf1, unf1;
    logic [7:0] dataOut1;
    logic [4:0] fillCount1;

    int checks = 0;
    int errors = 0;

    logic [7:0] mQueue[$];
    bit         mOvf;
    bit         mUnf;
    logic [7:0] mData0;

    typedef struct {
        bit         wr;
        logic [7:0] wd;
        bit         rd;
        bit         clr;
        int         cnt;
        bit         empty;
        bit         unf;
        logic [7:0] d0;
        logic [7:0] d1;
    } vector_t;

    vector_t vectors[10];

    sync_fifo_param #(.DATA_W(8), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b0)) dut0 (
        .clk            (clk),
        .reset_n        (reset_n),
        .clear          (clear),
        .wr_en          (wrEn),
        .wr_data        (wrData),
        .w_full         (wFull0),
        .w_almost_full  (wAf0),
        .rd_en          (rdEn),
        .data_out       (dataOut0),
        .r_empty        (rEmpty0),
        .r_almost_empty (rAe0),
        .fill_count     (fillCount0),
        .overflow       (ovf0),
        .underflow      (unf0)
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b1)) dut1 (
        .clk            (clk),
        .reset_n        (reset_n),
        .clear          (clear),
        .wr_en          (wrEn),
        .wr_data        (wrData),
        .w_full         (wFull1),
        .w_almost_full  (wAf1),
        .rd_en          (rdEn),
        .data_out       (dataOut1),
        .r_empty        (rEmpty1),
        .r_almost_empty (rAe1),
        .fill_count     (fillCount1),
        .overflow       (ovf1),
        .underflow      (unf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void checkVal(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void modelReset();
        mQueue.delete();
        mOvf   = 1'b0;
        mUnf   = 1'b0;
        mData0 = 8'h00;
    endfunction

    // Behavioural view: a queue of stored words; decisions use the state before the edge.
    function automatic void modelStep(input bit wr, input logic [7:0] wd, input bit rd, input bit clr);
        bit full;
        bit empty;
        if (clr) begin
            mQueue.delete();
            mOvf = 1'b0;
            mUnf = 1'b0;
            return;
        end
        full  = (mQueue.size() == DEPTH);
        empty = (mQueue.size() == 0);
        if (wr && full) mOvf = 1'b1;
        if (rd && empty) mUnf = 1'b1;
        if (rd && !empty) mData0 = mQueue.pop_front();
        if (wr && !full) mQueue.push_back(wd);
    endfunction

    task automatic checkOutput();
        int unsigned cnt;
        logic [7:0]  head;
        cnt  = mQueue.size();
        head = (cnt == 0) ? 8'h00 : mQueue[0];
        checkVal("fill_count0", fillCount0, cnt);
        checkVal("w_full0", wFull0, cnt == DEPTH);
        checkVal("w_almost_full0", wAf0, cnt >= AF);
        checkVal("r_empty0", rEmpty0, cnt == 0);
        checkVal("r_almost_empty0", rAe0, cnt <= AE);
        checkVal("overflow0", ovf0, mOvf);
        checkVal("underflow0", unf0, mUnf);
        checkVal("data_out0", dataOut0, mData0);
        checkVal("fill_count1", fillCount1, cnt);
        checkVal("w_full1", wFull1, cnt == DEPTH);
        checkVal("w_almost_full1", wAf1, cnt >= AF);
        checkVal("r_empty1", rEmpty1, cnt == 0);
        checkVal("r_almost_empty1", rAe1, cnt <= AE);
        checkVal("overflow1", ovf1, mOvf);
        checkVal("underflow1", unf1, mUnf);
        checkVal("data_out1", dataOut1, head);
    endtask

    task automatic applyStimulus(input bit wr, input logic [7:0] wd, input bit rd, input bit clr);
        wrEn   = wr;
        wrData = wd;
        rdEn   = rd;
        clear  = clr;
        @(posedge clk);
        modelStep(wr, wd, rd, clr);
        #1;
        checkOutput();
    endtask

    initial begin
        vectors[0] = '{1'b1, 8'hA1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 8'h00, 8'hA1};
        vectors[1] = '{1'b1, 8'hB2, 1'b0, 1'b0, 2, 1'b0, 1'b0, 8'h00, 8'hA1};
        vectors[2] = '{1'b1, 8'hC3, 1'b0, 1'b0, 3, 1'b0, 1'b0, 8'h00, 8'hA1};
        vectors[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b0, 1'b0, 8'hA1, 8'hB2};
        vectors[4] = '{1'b1, 8'hD4, 1'b1, 1'b0, 2, 1'b0, 1'b0, 8'hB2, 8'hC3};
        vectors[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 8'hC3, 8'hD4};
        vectors[6] = '{1'b1, 8'hE5, 1'b1, 1'b0, 1, 1'b0, 1'b0, 8'hD4, 8'hE5};
        vectors[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 8'hE5, 8'h00};
        vectors[8] = '{1'b1, 8'h77, 1'b1, 1'b0, 1, 1'b0, 1'b1, 8'hE5, 8'h77};
        vectors[9] = '{1'b1, 8'h99, 1'b0, 1'b1, 0, 1'b1, 1'b0, 8'hE5, 8'h00};

        reset_n = 1'b0;
        clear   = 1'b0;
        wrEn    = 1'b0;
        wrData  = 8'h00;
        rdEn    = 1'b0;
        modelReset();
        #1;
        checkVal("reset_fill_count", fillCount0, 0);
        checkVal("reset_r_empty", rEmpty0, 1);
        checkVal("reset_r_almost_empty", rAe0, 1);
        checkVal("reset_w_almost_full", wAf0, 0);
        checkOutput();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Fixed vectors with hand-derived expectations.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vectors[i].wr, vectors[i].wd, vectors[i].rd, vectors[i].clr);
            checkVal($sformatf("vec%0d_count", i), fillCount0, vectors[i].cnt);
            checkVal($sformatf("vec%0d_empty", i), rEmpty0, vectors[i].empty);
            checkVal($sformatf("vec%0d_underflow", i), unf0, vectors[i].unf);
            checkVal($sformatf("vec%0d_data0", i), dataOut0, vectors[i].d0);
            checkVal($sformatf("vec%0d_data1", i), dataOut1, vectors[i].d1);
        end

        // Fill to full, then one rejected write.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
            checkVal($sformatf("fill%0d_af", i), wAf0, (i + 1) >= 14);
            checkVal($sformatf("fill%0d_full", i), wFull0, (i + 1) == 16);
        end
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
        checkVal("extra_write_overflow", ovf0, 1);
        checkVal("extra_write_count", fillCount0, 16);

        // Drain in order, then one rejected read.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkVal($sformatf("drain%0d_data", i), dataOut0, i);
        end
        checkVal("drain_empty", rEmpty0, 1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkVal("extra_read_underflow", unf0, 1);
        checkVal("extra_read_hold", dataOut0, 8'h0F);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // FWFT word appears without a read request and vanishes when read.
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        checkVal("fwft_visible", dataOut1, 8'hA5);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkVal("fwft_empty", rEmpty1, 1);
        checkVal("fwft_zero", dataOut1, 8'h00);

        // Steady stream at fill level 3 across pointer wrap.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 8'(8'h43 + i), 1'b1, 1'b0);
            checkVal($sformatf("stream%0d_count", i), fillCount0, 3);
            checkVal($sformatf("stream%0d_data", i), dataOut0, 8'(8'h40 + i));
        end

        // Full FIFO with simultaneous read and write: write rejected.
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0);
        checkVal("full_rw_count", fillCount0, 15);
        checkVal("full_rw_overflow", ovf0, 1);
        checkVal("full_rw_data", dataOut0, 8'h80);

        // Flush with a concurrent write request.
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b1);
        checkVal("clear_count", fillCount0, 0);
        checkVal("clear_empty", rEmpty0, 1);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h24, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        modelReset();
        #1;
        checkVal("async_reset_count", fillCount0, 0);
        checkVal("async_reset_data0", dataOut0, 0);
        checkOutput();
        wrEn = 1'b0;
        rdEn = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        checkOutput();
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
        checkVal("post_reset_count", fillCount0, 1);
        checkVal("post_reset_fwft", dataOut1, 8'h3C);

        // Randomised traffic with shifting write/read bias.
        for (int phase = 0; phase < 6; phase++) begin
            int wrProb;
            int rdProb;
            wrProb = (phase % 3 == 0) ? 85 : ((phase % 3 == 1) ? 25 : 55);
            rdProb = (phase % 3 == 0) ? 25 : ((phase % 3 == 1) ? 85 : 55);
            for (int i = 0; i < 80; i++) begin
                applyStimulus($urandom_range(0, 99) < wrProb, 8'($urandom),
                              $urandom_range(0, 99) < rdProb, $urandom_range(0, 99) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Single-clock, parametrised FIFO: the same-clock-domain counterpart of the asynchronous FIFO, generalised in data width and depth. Adds programmable almost-full/almost-empty thresholds, an exact fill count, sticky overflow/underflow error flags, a synchronous flush and a selectable first-word-fall-through (FWFT) read mode. Used for rate buffering between producer and consumer blocks that share one clock.

## Interface

Parameters:
- DATA_W, 8, data word width in bits (≥1).
- DEPTH, 16, number of entries; power of two, ≥4.
- AF_LEVEL, DEPTH-2, w_almost_full asserts when fill_count ≥ AF_LEVEL.
- AE_LEVEL, 2, r_almost_empty asserts when fill_count ≤ AE_LEVEL.
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports (ADDR_W = log2(DEPTH)):
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush, active high.
- wr_en  in  1  write request.
- wr_data  in  DATA_W  write word.
- w_full  out  1  fill_count == DEPTH.
- w_almost_full  out  1  fill_count ≥ AF_LEVEL.
- rd_en  in  1  read request.
- data_out  out  DATA_W  read word.
- r_empty  out  1  fill_count == 0.
- r_almost_empty  out  1  fill_count ≤ AE_LEVEL.
- fill_count  out  ADDR_W+1  entries currently stored, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

## Operation

- Write accepted iff wr_en && !w_full: wr_data stored at wr_ptr, wr_ptr increments mod DEPTH.
- Read accepted iff rd_en && !r_empty: rd_ptr increments mod DEPTH.
- No pass-through when full: write with w_full=1 is rejected even if a read is accepted that cycle. Write with r_empty=1 plus rd_en: write accepted, read rejected.
- fill_count: +1 write only, −1 read only, unchanged both or neither. Never exceeds DEPTH or goes below 0.
- Pointers ADDR_W bits, wrap DEPTH−1 → 0 without disturbing fill_count.
- overflow set on wr_en && w_full; underflow set on rd_en && r_empty; both stay set until clear or reset.
- clear: pointers, fill_count, overflow, underflow → 0; wr_en/rd_en in the same cycle ignored; storage contents untouched. FWFT=0: data_out holds; FWFT=1: data_out → 0.
- FWFT=0: data_out is a register loaded with the head word on an accepted read; otherwise holds.
- FWFT=1: data_out = head word whenever r_empty=0, forced to 0 when empty; an accepted read advances to the next word.
- All status outputs are decoded from the fill_count register only (no wr_en/rd_en combinational paths to flags).

## Timing

- Reset (reset_n low, asynchronous): fill_count=0, r_empty=1, w_full=0, r_almost_empty=1, w_almost_full=0 (AF_LEVEL>0), overflow=0, underflow=0, data_out=0, pointers 0. Release synchronous to clk.
- Reset mid-operation discards all contents; first post-reset write behaves as into empty FIFO.
- Write edge N into empty FIFO: r_empty falls after edge N; FWFT=1 word visible on data_out after edge N.
- FWFT=0 read latency: rd_en accepted at edge N → word on data_out after edge N.
- w_full rises after the edge accepting the DEPTH-th write; falls after the edge accepting a read.
- Simultaneous accepted read + write when fill_count=1: both succeed, r_empty stays 0.
- Throughput: one write and one read per cycle sustained.

## Structure

- Package sync_fifo_pkg: clog2 function, default DATA_W/DEPTH constants, fill-count width helper.
- Sub-module fifo_ram: DEPTH×DATA_W simple dual-port array, synchronous write, asynchronous read; top level holds pointers, count, flags and output register.
- Elaboration-time check: DEPTH power of two, AE_LEVEL < AF_LEVEL ≤ DEPTH.

## Test plan

- Reset, then 16 writes 0x00..0x0F (DEPTH=16) → w_almost_full after 14th, w_full after 16th, fill_count=16; 17th write → overflow=1, fill_count stays 16.
- Drain 16 reads, FWFT=0 → data_out 0x00..0x0F in order, one cycle after each rd_en; r_empty after 16th; extra rd_en → underflow=1, data_out holds 0x0F.
- Continuous write+read for 40 cycles from fill_count=3 → fill_count constant 3, data in order across pointer wrap.
- FWFT=1: write 0xA5 into empty FIFO → data_out=0xA5 next cycle without rd_en; rd_en → r_empty=1, data_out=0.
- Full FIFO, wr_en+rd_en same cycle → read accepted, write rejected, overflow=1, fill_count=15.
- Fill 5 words, assert clear with wr_en → fill_count=0, flags cleared; reset_n pulse mid-burst → all outputs at reset values immediately, asynchronously.
